step_scheduler: RTL and testbench
=================================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 SHALL have parameter NUM_PART, default 4, the number of particle update engines sequenced.
REQ-002 SHALL have parameter TICK_CYCLES, default 10000, the clk cycles per simulation step period.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum cycles to wait for one particle's done.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 run  input  1  level; 1 = free-running stepping on tick, 0 = paused.
REQ-007 step_req  input  1  single-cycle pulse; requests one step while paused.
REQ-008 start  output  NUM_PART  one-hot, single-cycle pulse launching particle i's update.
REQ-009 done  input  NUM_PART  particle i pulses done[i] when its new state is computed.
REQ-010 commit  output  1  single-cycle pulse; all particles load computed state together.
REQ-011 frame_valid  output  1  held high until accepted; display may latch a new matrix.
REQ-012 frame_ready  input  1  display acceptance; transfer occurs when frame_valid and frame_ready are both high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  sticky; set when any particle misses its done deadline.
REQ-015 overrun  output  1  sticky; set when a tick arrives while a pending tick is already queued.
REQ-016 step_count  output  16  number of completed commits, wraps 0xFFFF->0.

Function
REQ-017 Tick counter SHALL count 0..TICK_CYCLES-1 continuously, emitting a one-cycle tick on its wrap, independent of run.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, COMMIT, PRESENT.
REQ-019 IDLE->ISSUE with idx=0 when (run and (tick or pending)) or (!run and step_req); pending is cleared on this transition.
REQ-020 A tick in any non-IDLE state SHALL set pending; a tick while pending is already set SHALL set overrun, and pending stays 1.
REQ-021 step_req SHALL be ignored when run=1 or busy=1.
REQ-022 ISSUE SHALL assert start[idx] for exactly one cycle, clear the wait counter, and go to WAIT_DONE next cycle.
REQ-023 WAIT_DONE SHALL advance on done[idx]=1; other done bits SHALL be ignored.
REQ-024 On advance, idx<NUM_PART-1 SHALL go to ISSUE with idx+1, else to COMMIT.
REQ-025 If done[idx] is absent for TIMEOUT_CYCLES cycles after start, the FSM SHALL set timeout_err and advance as if done arrived.
REQ-026 A done[idx] arriving in the same cycle as the start pulse SHALL NOT be accepted; the earliest acceptance is the cycle after start.
REQ-027 COMMIT SHALL pulse commit for one cycle, increment step_count, and go to PRESENT.
REQ-028 PRESENT SHALL hold frame_valid=1 until frame_valid and frame_ready are both high, then go to IDLE the next cycle.
REQ-029 Minimum step latency, from IDLE trigger to commit with done returned the cycle after each start, SHALL be 2*NUM_PART+1 cycles.
REQ-030 Deasserting run mid-step SHALL NOT abort the step; the FSM SHALL complete through PRESENT, and a pending tick is then held until run=1.

Reset
REQ-031 On reset the FSM SHALL go to IDLE, set idx=0, and clear the tick counter, wait counter, pending, timeout_err, overrun and step_count.
REQ-032 During and after reset, start=0, commit=0, frame_valid=0 and busy=0.
REQ-033 Reset mid-step SHALL abandon the step with no commit pulse.

Structure
REQ-034 The shared package step_pkg SHALL hold the state enum and the default NUM_PART, TICK_CYCLES and TIMEOUT_CYCLES constants.
REQ-035 The tick counter SHALL be a sub-module, tick_divider (parameter PERIOD, output tick).
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 run=1, TICK_CYCLES=100, done returned 3 cycles after each start, frame_ready=1 -> start order 0001,0010,0100,1000; one commit per tick; step_count increments by 1 per step.
REQ-038 Particle 2 never responds, TIMEOUT_CYCLES=64 -> start[3] fires 64 cycles after start[2]; timeout_err=1; commit still occurs.
REQ-039 run=0, step_req pulsed once -> exactly one step (one commit, step_count=1); a second step_req while busy is ignored.
REQ-040 frame_ready held 0 for 500 cycles with TICK_CYCLES=100 -> frame_valid held high throughout; pending=1 and overrun=1; after frame_ready=1, the next step starts immediately from the pending tick.
REQ-041 Reset asserted during WAIT_DONE for idx=1 -> no commit; all outputs zero; next step begins with start[0].
REQ-042 done[idx] coincident with the start pulse -> not accepted; the step advances only on a later done or on timeout.

Source files
------------

// File: rtl/step_pkg.sv
// Shared definitions for the particle step scheduler: FSM state encoding and
// default timing constants.
package step_pkg;

    localparam int DEF_NUM_PART       = 4;
    localparam int DEF_TICK_CYCLES    = 10000;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_PRESENT   = 3'd4
    } step_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running period divider: emits a one-cycle tick each time the counter
// wraps from PERIOD-1 back to 0.
module tick_divider #(
    parameter int PERIOD = 10000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(PERIOD - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/step_scheduler.sv
// Sequences NUM_PART particle update engines one at a time each simulation
// step, then commits all results together and presents a frame to the display.
module step_scheduler
    import step_pkg::*;
#(
    parameter int NUM_PART       = DEF_NUM_PART,
    parameter int TICK_CYCLES    = DEF_TICK_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                step_req,
    output logic [NUM_PART-1:0] start,
    input  logic [NUM_PART-1:0] done,
    output logic                commit,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                busy,
    output logic                timeout_err,
    output logic                overrun,
    output logic [15:0]         step_count
);

    localparam int IDX_W  = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    step_state_t        state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               pending;
    logic               tick;
    logic               trigger;
    logic               miss;

    tick_divider #(
        .PERIOD (TICK_CYCLES)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        trigger = 1'b0;
        miss    = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((run && (tick || pending)) || (!run && step_req)) begin
                    state_n = ST_ISSUE;
                    idx_n   = '0;
                    trigger = 1'b1;
                end
            end
            ST_ISSUE: state_n = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // A deadline miss advances exactly like a real done.
                miss = !done[idx] && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
                if (done[idx] || miss) begin
                    if (idx == IDX_W'(NUM_PART - 1)) begin
                        state_n = ST_COMMIT;
                    end else begin
                        state_n = ST_ISSUE;
                        idx_n   = idx + 1'b1;
                    end
                end
            end
            ST_COMMIT: state_n = ST_PRESENT;
            ST_PRESENT: begin
                if (frame_valid && frame_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            pending     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            step_count  <= '0;
            start       <= '0;
            commit      <= 1'b0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;

            // The start cycle itself counts toward the deadline.
            if (state == ST_ISSUE) begin
                wait_cnt <= WAIT_W'(1);
            end else if (state == ST_WAIT_DONE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (trigger) begin
                pending <= 1'b0;
            end else if (tick && state != ST_IDLE) begin
                pending <= 1'b1;
                if (pending) begin
                    overrun <= 1'b1;
                end
            end

            if (miss) begin
                timeout_err <= 1'b1;
            end

            if (state_n == ST_COMMIT) begin
                step_count <= step_count + 1'b1;
            end

            // Outputs are registered from the next state so they align with it.
            start <= '0;
            if (state_n == ST_ISSUE) begin
                start[idx_n] <= 1'b1;
            end
            commit      <= (state_n == ST_COMMIT);
            frame_valid <= (state_n == ST_PRESENT);
            busy        <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler: free-run stepping, single step, timeouts,
// coincident done, display backpressure and reset mid-step.
module tb_step_scheduler;

    localparam int NP    = 4;
    localparam int TICKS = 100;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          reset, run, step_req, frame_ready;
    logic [NP-1:0] done, start;
    logic          commit, frame_valid, busy, timeout_err, overrun;
    logic [15:0]   step_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int            resp_cnt [NP];
    int            resp_delay;
    logic [NP-1:0] mute_mask, coin_mask;

    logic [NP-1:0] start_log [$];
    int            start_cyc [$];
    int            commit_cyc [$];
    int            commit_sc [$];

    step_scheduler #(
        .NUM_PART       (NP),
        .TICK_CYCLES    (TICKS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step_req    (step_req),
        .start       (start),
        .done        (done),
        .commit      (commit),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun     (overrun),
        .step_count  (step_count)
    );

    always #5 clk = ~clk;

    // One clock: sample after the edge, model the particle engines, log events.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        done = '0;
        for (int i = 0; i < NP; i++) begin
            if (resp_cnt[i] > 0) begin
                resp_cnt[i]--;
                if (resp_cnt[i] == 0) done[i] = 1'b1;
            end
        end
        if (start != '0) begin
            start_log.push_back(start);
            start_cyc.push_back(cyc);
            for (int i = 0; i < NP; i++) begin
                if (start[i]) begin
                    if (coin_mask[i]) done[i] = 1'b1;
                    if (!mute_mask[i]) resp_cnt[i] = resp_delay;
                end
            end
        end
        if (commit) begin
            commit_cyc.push_back(cyc);
            commit_sc.push_back(int'(step_count));
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        run         = 1'b0;
        step_req    = 1'b0;
        frame_ready = 1'b1;
        done        = '0;
        mute_mask   = '0;
        coin_mask   = '0;
        resp_delay  = 1;
        for (int i = 0; i < NP; i++) resp_cnt[i] = 0;
        repeat (3) cycle();
        reset = 1'b0;
        start_log.delete();
        start_cyc.delete();
        commit_cyc.delete();
        commit_sc.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; step_req = 1'b1; frame_ready = 1'b1;
        done = '0; mute_mask = '0; coin_mask = '0; resp_delay = 1;
        for (int i = 0; i < NP; i++) resp_cnt[i] = 0;
        repeat (2) cycle();
        checks++; if (start !== '0) begin failures++; $display("FAIL reset_start: got %b expected 0000", start); end
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL reset_commit: got %b expected 0", commit); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (timeout_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_sticky: got %b%b expected 00", timeout_err, overrun); end
        checks++; if (step_count !== 16'd0) begin failures++; $display("FAIL reset_step_count: got %0d expected 0", step_count); end
        step_req = 1'b0;
    endtask

    task automatic test_run();
        logic [NP-1:0] exp_s;
        apply_reset();
        run = 1'b1;
        resp_delay = 3;
        while (cyc < 450) begin
            cycle();
            step_req = (cyc == 50);
        end
        step_req = 1'b0;
        checks++; if (start_cyc.size() !== 16) begin failures++; $display("FAIL run_start_count: got %0d expected 16", start_cyc.size()); end
        if (start_cyc.size() >= 8) begin
            checks++; if (start_cyc[0] !== 101) begin failures++; $display("FAIL run_first_start: got %0d expected 101", start_cyc[0]); end
            checks++; if (start_cyc[1] - start_cyc[0] !== 4) begin failures++; $display("FAIL run_start_spacing: got %0d expected 4", start_cyc[1] - start_cyc[0]); end
            for (int k = 0; k < 8; k++) begin
                exp_s = NP'(1) << (k % NP);
                checks++; if (start_log[k] !== exp_s) begin failures++; $display("FAIL run_order[%0d]: got %b expected %b", k, start_log[k], exp_s); end
            end
        end
        checks++; if (commit_cyc.size() !== 4) begin failures++; $display("FAIL run_commit_count: got %0d expected 4", commit_cyc.size()); end
        if (commit_cyc.size() >= 4) begin
            checks++; if (commit_cyc[0] !== 117) begin failures++; $display("FAIL run_commit_cycle: got %0d expected 117", commit_cyc[0]); end
            for (int k = 0; k < 4; k++) begin
                checks++; if (commit_sc[k] !== k + 1) begin failures++; $display("FAIL run_step_count[%0d]: got %0d expected %0d", k, commit_sc[k], k + 1); end
            end
        end
        checks++; if (step_count !== 16'd4) begin failures++; $display("FAIL run_final_count: got %0d expected 4", step_count); end
        checks++; if (timeout_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL run_sticky: got %b%b expected 00", timeout_err, overrun); end
    endtask

    task automatic test_step_req();
        apply_reset();
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        checks++; if (start !== 4'b0001) begin failures++; $display("FAIL step_first_start: got %b expected 0001", start); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL step_busy: got %b expected 1", busy); end
        repeat (2) cycle();
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        while (cyc < 40) cycle();
        checks++; if (commit_cyc.size() !== 1) begin failures++; $display("FAIL step_commit_count: got %0d expected 1", commit_cyc.size()); end
        if (commit_cyc.size() >= 1) begin
            checks++; if (commit_cyc[0] !== 9) begin failures++; $display("FAIL step_latency: got %0d expected 9", commit_cyc[0]); end
        end
        checks++; if (start_cyc.size() !== 4) begin failures++; $display("FAIL step_start_count: got %0d expected 4", start_cyc.size()); end
        checks++; if (step_count !== 16'd1) begin failures++; $display("FAIL step_count: got %0d expected 1", step_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL step_idle: got %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        apply_reset();
        mute_mask = 4'b0100;
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        while (cyc < 68) cycle();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_early: got %b expected 0", timeout_err); end
        while (cyc < 90) cycle();
        checks++; if (start_cyc.size() !== 4) begin failures++; $display("FAIL tmo_start_count: got %0d expected 4", start_cyc.size()); end
        if (start_cyc.size() >= 4) begin
            checks++; if (start_cyc[2] !== 5) begin failures++; $display("FAIL tmo_start2: got %0d expected 5", start_cyc[2]); end
            checks++; if (start_cyc[3] - start_cyc[2] !== 64) begin failures++; $display("FAIL tmo_gap: got %0d expected 64", start_cyc[3] - start_cyc[2]); end
        end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b expected 1", timeout_err); end
        checks++; if (commit_cyc.size() !== 1) begin failures++; $display("FAIL tmo_commit: got %0d expected 1", commit_cyc.size()); end
        checks++; if (step_count !== 16'd1) begin failures++; $display("FAIL tmo_step_count: got %0d expected 1", step_count); end
    endtask

    task automatic test_coincident();
        apply_reset();
        coin_mask  = 4'b0001;
        resp_delay = 5;
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        while (cyc < 40) cycle();
        checks++; if (start_cyc.size() !== 4) begin failures++; $display("FAIL coin_start_count: got %0d expected 4", start_cyc.size()); end
        if (start_cyc.size() >= 2) begin
            checks++; if (start_cyc[1] - start_cyc[0] !== 6) begin failures++; $display("FAIL coin_gap: got %0d expected 6", start_cyc[1] - start_cyc[0]); end
        end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL coin_no_tmo: got %b expected 0", timeout_err); end

        apply_reset();
        coin_mask = 4'b0001;
        mute_mask = 4'b0001;
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        while (cyc < 80) cycle();
        if (start_cyc.size() >= 2) begin
            checks++; if (start_cyc[1] - start_cyc[0] !== 64) begin failures++; $display("FAIL coin_only_gap: got %0d expected 64", start_cyc[1] - start_cyc[0]); end
        end else begin
            checks++; failures++; $display("FAIL coin_only_starts: got %0d expected >=2", start_cyc.size());
        end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL coin_only_tmo: got %b expected 1", timeout_err); end
        checks++; if (commit_cyc.size() !== 1) begin failures++; $display("FAIL coin_only_commit: got %0d expected 1", commit_cyc.size()); end
    endtask

    task automatic test_backpressure();
        int fv_drop;
        logic ov250;
        apply_reset();
        run = 1'b1;
        frame_ready = 1'b0;
        fv_drop = 0;
        ov250 = 1'bx;
        while (cyc < 610) begin
            cycle();
            if (cyc >= 110 && frame_valid !== 1'b1) fv_drop++;
            if (cyc == 250) ov250 = overrun;
        end
        if (commit_cyc.size() >= 1) begin
            checks++; if (commit_cyc[0] !== 109) begin failures++; $display("FAIL bp_commit_cycle: got %0d expected 109", commit_cyc[0]); end
        end
        checks++; if (fv_drop !== 0) begin failures++; $display("FAIL bp_valid_held: got %0d drops expected 0", fv_drop); end
        checks++; if (ov250 !== 1'b0) begin failures++; $display("FAIL bp_single_pending: got overrun=%b expected 0", ov250); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
        checks++; if (commit_cyc.size() !== 1) begin failures++; $display("FAIL bp_one_commit: got %0d expected 1", commit_cyc.size()); end
        frame_ready = 1'b1;
        cycle();
        checks++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_accept: got valid=%b busy=%b expected 0 0", frame_valid, busy); end
        cycle();
        checks++; if (start !== 4'b0001) begin failures++; $display("FAIL bp_pending_restart: got %b expected 0001", start); end
        while (cyc < 640) cycle();
        checks++; if (step_count !== 16'd2) begin failures++; $display("FAIL bp_step_count: got %0d expected 2", step_count); end
    endtask

    task automatic test_reset_mid();
        int ncommit;
        apply_reset();
        mute_mask = 4'b0010;
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        while (cyc < 10) cycle();
        checks++; if (busy !== 1'b1 || start_cyc.size() !== 2) begin failures++; $display("FAIL mid_in_wait: got busy=%b starts=%0d expected 1 2", busy, start_cyc.size()); end
        reset = 1'b1;
        cycle();
        checks++; if (start !== '0 || commit !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_outputs: got start=%b commit=%b valid=%b busy=%b expected all 0", start, commit, frame_valid, busy);
        end
        checks++; if (step_count !== 16'd0) begin failures++; $display("FAIL mid_step_count: got %0d expected 0", step_count); end
        cycle();
        reset = 1'b0;
        mute_mask = '0;
        repeat (3) cycle();
        ncommit = commit_cyc.size();
        checks++; if (ncommit !== 0) begin failures++; $display("FAIL mid_no_commit: got %0d expected 0", ncommit); end
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        checks++; if (start !== 4'b0001) begin failures++; $display("FAIL mid_restart: got %b expected 0001", start); end
        repeat (20) cycle();
        checks++; if (step_count !== 16'd1) begin failures++; $display("FAIL mid_step_count_after: got %0d expected 1", step_count); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step_req();
        test_timeout();
        test_coincident();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
